dac_window_discriminator: RTL and testbench

- Per-DAC-channel spike window discriminator, one sample per `sample_valid` strobe.
- Sits downstream of the DAC-path high-pass filter and consumes its 16-bit offset-binary output.
- A trigger crossing of threshold 1 starts a sample-indexed window sequence. The block emits a one-cycle detect pulse when threshold 1 is met in window 1 and threshold 2 is met in window 2, both before `stop_max`.
- Drives the DAC threshold digital output and the 32-bit `fsm_window_state` debug word.

---
 rtl/dac_window_discriminator.sv | 158 +++++++++++++++
 tb/tb_dac_window_discriminator.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_window_discriminator.sv
// Spike window discriminator: a trigger on threshold 1 opens sample-indexed windows; detect pulses one cycle after the deciding strobe.
// No backpressure: every sample_valid strobe is consumed, including one arriving in the decision cycle.
module dac_window_discriminator #(
    parameter int WIDTH       = 16,
    parameter int STATE_DBG_W = 32
) (
    input  logic                   dataclk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   fsm_mode,
    input  logic                   sample_valid,
    input  logic [WIDTH-1:0]       sample_in,
    input  logic [WIDTH-1:0]       thrsh_1,
    input  logic [WIDTH-1:0]       thrsh_2,
    input  logic                   thrsh_pol_1,
    input  logic                   thrsh_pol_2,
    input  logic [1:0]             edge_type,
    input  logic [WIDTH-1:0]       start_win_1,
    input  logic [WIDTH-1:0]       stop_win_1,
    input  logic [WIDTH-1:0]       start_win_2,
    input  logic [WIDTH-1:0]       stop_win_2,
    input  logic [WIDTH-1:0]       stop_max,
    output logic                   thresh_out,
    output logic [STATE_DBG_W-1:0] fsm_window_state
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_ARMED = 4'd1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] k, k_nxt, k_eval;
    logic             win1_hit, win1_hit_nxt;
    logic             win2_hit, win2_hit_nxt;
    logic             prev_cond1, prev_cond1_nxt;
    logic             out_nxt;
    logic [WIDTH-1:0] s1_q, e1_q, s2_q, e2_q, max_q;
    logic [WIDTH-1:0] s1_nxt, e1_nxt, s2_nxt, e2_nxt, max_nxt;
    logic             cond1, cond2, trigger, evaluate, started;
    logic             hit1, hit2;
    logic [STATE_DBG_W-1:0] dbg_nxt;

    always_comb begin
        cond1 = thrsh_pol_1 ? (sample_in >= thrsh_1) : (sample_in <= thrsh_1);
        cond2 = thrsh_pol_2 ? (sample_in >= thrsh_2) : (sample_in <= thrsh_2);
        case (edge_type)
            2'b01:   trigger = !cond1 && prev_cond1;
            2'b10:   trigger = cond1 && !prev_cond1;
            default: trigger = cond1;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        k_nxt          = k;
        win1_hit_nxt   = win1_hit;
        win2_hit_nxt   = win2_hit;
        prev_cond1_nxt = sample_valid ? cond1 : prev_cond1;
        out_nxt        = fsm_mode ? 1'b0 : thresh_out;
        s1_nxt         = s1_q;
        e1_nxt         = e1_q;
        s2_nxt         = s2_q;
        e2_nxt         = e2_q;
        max_nxt        = max_q;
        k_eval         = '0;
        evaluate       = 1'b0;
        started        = 1'b0;
        hit1           = 1'b0;
        hit2           = 1'b0;

        if (!enable || !fsm_mode) begin
            // Covers disable, bypass and a mode switch mid-window: the window is dropped silently.
            state_nxt    = ST_IDLE;
            k_nxt        = '0;
            win1_hit_nxt = 1'b0;
            win2_hit_nxt = 1'b0;
            if (!enable)
                out_nxt = 1'b0;
            else if (sample_valid)
                out_nxt = cond1;
        end else if (sample_valid) begin
            if (state == ST_IDLE) begin
                if (trigger) begin
                    s1_nxt   = start_win_1;
                    e1_nxt   = stop_win_1;
                    s2_nxt   = start_win_2;
                    e2_nxt   = stop_win_2;
                    max_nxt  = stop_max;
                    k_eval   = '0;
                    evaluate = 1'b1;
                    started  = 1'b1;
                end
            end else begin
                k_eval   = k + WIDTH'(1);
                evaluate = 1'b1;
            end

            if (evaluate) begin
                // The trigger sample starts with clear hits rather than whatever is left in the registers.
                hit1 = (!started && win1_hit) ||
                       (cond1 && (k_eval >= s1_nxt) && (k_eval <= e1_nxt));
                hit2 = (!started && win2_hit) ||
                       (cond2 && (k_eval >= s2_nxt) && (k_eval <= e2_nxt));
                if (k_eval == max_nxt) begin
                    out_nxt      = hit1 && hit2;
                    state_nxt    = ST_IDLE;
                    k_nxt        = '0;
                    win1_hit_nxt = 1'b0;
                    win2_hit_nxt = 1'b0;
                end else begin
                    state_nxt    = ST_ARMED;
                    k_nxt        = k_eval;
                    win1_hit_nxt = hit1;
                    win2_hit_nxt = hit2;
                end
            end
        end

        dbg_nxt        = '0;
        dbg_nxt[31:28] = state_nxt;
        dbg_nxt[27]    = win1_hit_nxt;
        dbg_nxt[26]    = win2_hit_nxt;
        dbg_nxt[25]    = prev_cond1_nxt;
        dbg_nxt[15:0]  = 16'(k_nxt);
    end

    always_ff @(posedge dataclk) begin
        if (!reset) begin
            state            <= ST_IDLE;
            k                <= '0;
            win1_hit         <= 1'b0;
            win2_hit         <= 1'b0;
            prev_cond1       <= 1'b0;
            thresh_out       <= 1'b0;
            s1_q             <= '0;
            e1_q             <= '0;
            s2_q             <= '0;
            e2_q             <= '0;
            max_q            <= '0;
            fsm_window_state <= '0;
        end else begin
            state            <= state_nxt;
            k                <= k_nxt;
            win1_hit         <= win1_hit_nxt;
            win2_hit         <= win2_hit_nxt;
            prev_cond1       <= prev_cond1_nxt;
            thresh_out       <= out_nxt;
            s1_q             <= s1_nxt;
            e1_q             <= e1_nxt;
            s2_q             <= s2_nxt;
            e2_q             <= e2_nxt;
            max_q            <= max_nxt;
            fsm_window_state <= dbg_nxt;
        end
    end

endmodule

// File: tb/tb_dac_window_discriminator.sv
// Bench for dac_window_discriminator: behavioural scoreboard checked every clock plus per-scenario checks.
module tb_dac_window_discriminator;

    localparam logic [15:0] BASE = 16'd32000;  // meets neither condition, so window 2 only hits on 33000
    localparam logic [15:0] LOW  = 16'd30000;
    localparam logic [15:0] HIGH = 16'd33000;

    logic        dataclk = 1'b0;
    logic        reset, enable, fsm_mode, sample_valid;
    logic [15:0] sample_in, thrsh_1, thrsh_2;
    logic        thrsh_pol_1, thrsh_pol_2;
    logic [1:0]  edge_type;
    logic [15:0] start_win_1, stop_win_1, start_win_2, stop_win_2, stop_max;
    logic        thresh_out;
    logic [31:0] fsm_window_state;

    always #5 dataclk = ~dataclk;

    dac_window_discriminator #(.WIDTH(16), .STATE_DBG_W(32)) dut (
        .dataclk          (dataclk),
        .reset            (reset),
        .enable           (enable),
        .fsm_mode         (fsm_mode),
        .sample_valid     (sample_valid),
        .sample_in        (sample_in),
        .thrsh_1          (thrsh_1),
        .thrsh_2          (thrsh_2),
        .thrsh_pol_1      (thrsh_pol_1),
        .thrsh_pol_2      (thrsh_pol_2),
        .edge_type        (edge_type),
        .start_win_1      (start_win_1),
        .stop_win_1       (stop_win_1),
        .start_win_2      (start_win_2),
        .stop_win_2       (stop_win_2),
        .stop_max         (stop_max),
        .thresh_out       (thresh_out),
        .fsm_window_state (fsm_window_state)
    );

    typedef struct {
        logic        out;
        logic [31:0] dbg;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulse_cnt = 0;
    int   trig_cnt = 0;
    logic last_armed = 1'b0;
    logic first_out;

    // Reference model state
    bit m_armed, m_h1, m_h2, m_prev, m_out;
    int m_k, m_s1, m_e1, m_s2, m_e2, m_max;

    function automatic logic [31:0] m_dbg();
        logic [15:0] kf;
        kf = m_k[15:0];
        return {3'b000, m_armed, m_h1, m_h2, m_prev, 9'b0, kf};
    endfunction

    task automatic model_clear();
        m_armed = 0; m_k = 0; m_h1 = 0; m_h2 = 0;
    endtask

    task automatic model_step();
        bit c1, c2, trig;
        c1 = thrsh_pol_1 ? (sample_in >= thrsh_1) : (sample_in <= thrsh_1);
        c2 = thrsh_pol_2 ? (sample_in >= thrsh_2) : (sample_in <= thrsh_2);
        if (!reset) begin
            model_clear();
            m_prev = 0; m_out = 0;
            m_s1 = 0; m_e1 = 0; m_s2 = 0; m_e2 = 0; m_max = 0;
        end else if (!enable || !fsm_mode) begin
            model_clear();
            if (!enable) m_out = 0;
            else if (sample_valid) m_out = c1;
            if (sample_valid) m_prev = c1;
        end else begin
            m_out = 0;
            if (sample_valid) begin
                trig = (edge_type == 2'b01) ? (!c1 && m_prev) :
                       (edge_type == 2'b10) ? (c1 && !m_prev) : c1;
                if (!m_armed) begin
                    if (trig) begin
                        m_s1 = start_win_1; m_e1 = stop_win_1;
                        m_s2 = start_win_2; m_e2 = stop_win_2;
                        m_max = stop_max;
                        m_armed = 1; m_k = 0; m_h1 = 0; m_h2 = 0;
                    end
                end else begin
                    m_k++;
                end
                if (m_armed) begin
                    if (c1 && m_k >= m_s1 && m_k <= m_e1) m_h1 = 1;
                    if (c2 && m_k >= m_s2 && m_k <= m_e2) m_h2 = 1;
                    if (m_k == m_max) begin
                        m_out = m_h1 && m_h2;
                        model_clear();
                    end
                end
                m_prev = c1;
            end
        end
    endtask

    // One clock: predict, push, let the edge happen, then pop and compare on the falling edge.
    task automatic step();
        exp_t e;
        model_step();
        e.out = m_out;
        e.dbg = m_dbg();
        sb.push_back(e);
        @(negedge dataclk);
        e = sb.pop_front();
        n_cmp++;
        if (thresh_out !== e.out) begin
            n_bad++;
            $display("FAIL sb_thresh_out t=%0t got %b want %b", $time, thresh_out, e.out);
        end
        n_cmp++;
        if (fsm_window_state !== e.dbg) begin
            n_bad++;
            $display("FAIL sb_state_word t=%0t got %h want %h", $time, fsm_window_state, e.dbg);
        end
        if (fsm_mode && thresh_out === 1'b1) pulse_cnt++;
        if (!last_armed && fsm_window_state[28] === 1'b1) trig_cnt++;
        last_armed = fsm_window_state[28];
    endtask

    task automatic strobe(input logic [15:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        step();
        first_out    = thresh_out;
        sample_valid = 1'b0;
        repeat (7) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
        pulse_cnt = 0;
        trig_cnt  = 0;
    endtask

    task automatic cfg_common();
        thrsh_1 = 16'd30973; thrsh_pol_1 = 1'b0;
        thrsh_2 = 16'd32255; thrsh_pol_2 = 1'b1;
        start_win_1 = 16'd0; stop_win_1 = 16'd2;
        start_win_2 = 16'd4; stop_win_2 = 16'd8;
        stop_max = 16'd8; edge_type = 2'b10;
        fsm_mode = 1'b1; enable = 1'b1;
    endtask

    // Two priming samples, trigger on LOW at k=0, then k=1..last_k with k5 at k=5.
    task automatic run_window(input logic [15:0] k5, input int last_k);
        strobe(BASE);
        strobe(BASE);
        strobe(LOW);
        for (int k = 1; k <= last_k; k++)
            strobe(k == 5 ? k5 : BASE);
    endtask

    task automatic test_reset();
        cfg_common();
        sample_in = BASE; sample_valid = 1'b0;
        reset = 1'b0;
        repeat (2) step();
        n_cmp++;
        if (thresh_out !== 1'b0) begin
            n_bad++; $display("FAIL reset_out got %b want 0", thresh_out);
        end
        n_cmp++;
        if (fsm_window_state !== 32'h0) begin
            n_bad++; $display("FAIL reset_word got %h want 00000000", fsm_window_state);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_full_detect();
        do_reset();
        run_window(HIGH, 7);
        n_cmp++;
        if (fsm_window_state[27:26] !== 2'b11) begin
            n_bad++; $display("FAIL detect_hits got %b want 11", fsm_window_state[27:26]);
        end
        strobe(BASE);
        n_cmp++;
        if (first_out !== 1'b1) begin
            n_bad++; $display("FAIL detect_pulse_timing got %b want 1", first_out);
        end
        n_cmp++;
        if (pulse_cnt !== 1) begin
            n_bad++; $display("FAIL detect_pulse_count got %0d want 1", pulse_cnt);
        end
        n_cmp++;
        if (fsm_window_state[31:28] !== 4'd0) begin
            n_bad++; $display("FAIL detect_idle got %0d want 0", fsm_window_state[31:28]);
        end
    endtask

    task automatic test_missing_win2();
        do_reset();
        run_window(BASE, 8);
        n_cmp++;
        if (pulse_cnt !== 0) begin
            n_bad++; $display("FAIL nowin2_pulses got %0d want 0", pulse_cnt);
        end
        n_cmp++;
        if (fsm_window_state !== 32'h0) begin
            n_bad++; $display("FAIL nowin2_word got %h want 00000000", fsm_window_state);
        end
    endtask

    task automatic test_edge();
        do_reset();
        strobe(BASE);
        repeat (20) strobe(LOW);
        n_cmp++;
        if (trig_cnt !== 1) begin
            n_bad++; $display("FAIL edge10_triggers got %0d want 1", trig_cnt);
        end
        n_cmp++;
        if (pulse_cnt !== 0) begin
            n_bad++; $display("FAIL edge10_pulses got %0d want 0", pulse_cnt);
        end
        do_reset();
        edge_type = 2'b00;
        strobe(BASE);
        repeat (20) strobe(LOW);
        n_cmp++;
        if (trig_cnt !== 3) begin
            n_bad++; $display("FAIL edge00_triggers got %0d want 3", trig_cnt);
        end
        n_cmp++;
        if (fsm_window_state[15:0] !== 16'd1) begin
            n_bad++; $display("FAIL edge00_k got %0d want 1", fsm_window_state[15:0]);
        end
        edge_type = 2'b10;
    endtask

    task automatic test_abort();
        do_reset();
        run_window(HIGH, 4);
        n_cmp++;
        if (fsm_window_state[27] !== 1'b1) begin
            n_bad++; $display("FAIL abort_win1_hit got %b want 1", fsm_window_state[27]);
        end
        enable = 1'b0;
        strobe(HIGH);
        n_cmp++;
        if (fsm_window_state[31:26] !== 6'd0 || fsm_window_state[15:0] !== 16'd0) begin
            n_bad++; $display("FAIL abort_word got %h want state/hits/k zero", fsm_window_state);
        end
        n_cmp++;
        if (pulse_cnt !== 0) begin
            n_bad++; $display("FAIL abort_pulses got %0d want 0", pulse_cnt);
        end
        enable = 1'b1;
        run_window(HIGH, 8);
        n_cmp++;
        if (pulse_cnt !== 1) begin
            n_bad++; $display("FAIL reenable_pulses got %0d want 1", pulse_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [15:0] vals [3];
        logic        want [3];
        vals = '{LOW, 16'd32768, LOW};
        want = '{1'b1, 1'b0, 1'b1};
        do_reset();
        fsm_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            strobe(vals[i]);
            n_cmp++;
            if (first_out !== want[i]) begin
                n_bad++; $display("FAIL bypass_update_%0d got %b want %b", i, first_out, want[i]);
            end
            n_cmp++;
            if (thresh_out !== want[i]) begin
                n_bad++; $display("FAIL bypass_hold_%0d got %b want %b", i, thresh_out, want[i]);
            end
        end
        fsm_mode = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_window(HIGH, 6);
        reset = 1'b0;
        step();
        n_cmp++;
        if (thresh_out !== 1'b0 || fsm_window_state !== 32'h0) begin
            n_bad++; $display("FAIL midreset_outputs got %b/%h want 0/00000000", thresh_out, fsm_window_state);
        end
        reset = 1'b1;
        strobe(BASE);
        strobe(BASE);
        n_cmp++;
        if (pulse_cnt !== 0) begin
            n_bad++; $display("FAIL midreset_pulses got %0d want 0", pulse_cnt);
        end
    endtask

    task automatic test_stop_max0();
        do_reset();
        thrsh_1 = 16'd32768; thrsh_2 = 16'd32768;
        start_win_1 = 16'd0; stop_win_1 = 16'd0;
        start_win_2 = 16'd0; stop_win_2 = 16'd0;
        stop_max = 16'd0;
        strobe(HIGH);
        strobe(16'd32768);
        n_cmp++;
        if (first_out !== 1'b1) begin
            n_bad++; $display("FAIL smax0_pulse got %b want 1", first_out);
        end
        n_cmp++;
        if (pulse_cnt !== 1) begin
            n_bad++; $display("FAIL smax0_pulse_count got %0d want 1", pulse_cnt);
        end
    endtask

    // Strobes on consecutive clocks with level trigger: each one decides and re-arms with no dead cycle.
    task automatic test_back_to_back();
        edge_type = 2'b00;
        pulse_cnt = 0;
        sample_in = 16'd32768;
        sample_valid = 1'b1;
        repeat (4) step();
        sample_valid = 1'b0;
        step();
        n_cmp++;
        if (pulse_cnt !== 4) begin
            n_bad++; $display("FAIL b2b_pulses got %0d want 4", pulse_cnt);
        end
        n_cmp++;
        if (thresh_out !== 1'b0) begin
            n_bad++; $display("FAIL b2b_after got %b want 0", thresh_out);
        end
    endtask

    initial begin
        test_reset();
        test_full_detect();
        test_missing_win2();
        test_edge();
        test_abort();
        test_bypass();
        test_reset_mid();
        test_stop_max0();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
